led_pattern_seq: RTL and testbench

- Parametrised LED pattern sequencer for the core-board LED bank. Replaces the fixed 4-LED, 1 s rotator.
- Adds configurable LED count, step rate, speed select, direction, four pattern modes, an enable, and selectable output polarity.
- Sits between the board clock and the LED pins. Exports a step strobe so other logic can synchronise to pattern changes.

---
 rtl/led_pattern_seq.sv | 141 ++++++++++++++
 tb/tb_led_pattern_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: rotate / bounce / blink / fill bar with prescaled step strobe.
// Optional PWM brightness gating is enabled by defining LED_PWM_DIM_EN.
module led_pattern_seq #(
  parameter int N_LED      = 4,
  parameter int CLK_HZ     = 50000000,
  parameter int STEP_HZ    = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [1:0]       speed,
`ifdef LED_PWM_DIM_EN
  input  logic [3:0]       bright,
`endif
  output logic [N_LED-1:0] led,
  output logic             step_tick
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int CW       = $clog2(TICK_DIV);

  localparam logic [CW:0]      LIMIT_BASE = (CW+1)'(TICK_DIV);
  localparam logic [N_LED-1:0] LSB_ONLY   = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [N_LED-1:0] MSB_ONLY   = {1'b1, {(N_LED-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_LED-1:0] pattern_q, pattern_d;
  logic             bounce_up_q, bounce_up_d;
  logic             step_tick_q, step_tick_d;
  logic [CW:0]      limit;
  mode_e            mode_in;

  assign limit   = LIMIT_BASE >> speed;
  assign mode_in = mode_e'(mode);

  always_comb begin
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    bounce_up_d = bounce_up_q;
    step_tick_d = 1'b0;

    // A mode change wins over any tick due on the same edge and restarts the prescaler.
    if (mode_in != mode_q) begin
      mode_d = mode_in;
      cnt_d  = '0;
      unique case (mode_in)
        MODE_ROTATE: pattern_d = dir ? MSB_ONLY : LSB_ONLY;
        MODE_BOUNCE: begin
          pattern_d   = LSB_ONLY;
          bounce_up_d = 1'b1;
        end
        MODE_BLINK:  pattern_d = '1;
        MODE_FILL:   pattern_d = '0;
      endcase
    end else if (en) begin
      if ({1'b0, cnt_q} >= limit - (CW+1)'(1)) begin
        cnt_d       = '0;
        step_tick_d = 1'b1;
        unique case (mode_q)
          MODE_ROTATE: begin
            if (dir) pattern_d = {pattern_q[0], pattern_q[N_LED-1:1]};
            else     pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
          end
          MODE_BOUNCE: begin
            // Reverse on the step that leaves an end, so each end is lit once.
            if (bounce_up_q) begin
              if (pattern_q[N_LED-1]) begin
                bounce_up_d = 1'b0;
                pattern_d   = {1'b0, pattern_q[N_LED-1:1]};
              end else begin
                pattern_d   = {pattern_q[N_LED-2:0], 1'b0};
              end
            end else begin
              if (pattern_q[0]) begin
                bounce_up_d = 1'b1;
                pattern_d   = {pattern_q[N_LED-2:0], 1'b0};
              end else begin
                pattern_d   = {1'b0, pattern_q[N_LED-1:1]};
              end
            end
          end
          MODE_BLINK: pattern_d = ~pattern_q;
          MODE_FILL:  pattern_d = (&pattern_q) ? '0 : {pattern_q[N_LED-2:0], 1'b1};
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_ROTATE;
      cnt_q       <= '0;
      pattern_q   <= LSB_ONLY;
      bounce_up_q <= 1'b1;
      step_tick_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      pattern_q   <= pattern_d;
      bounce_up_q <= bounce_up_d;
      step_tick_q <= step_tick_d;
    end
  end

  logic [N_LED-1:0] lit;

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_q, pwm_d;

  always_comb begin
    pwm_d = pwm_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_q <= '0;
    else     pwm_q <= pwm_d;
  end

  assign lit = pattern_q & {N_LED{pwm_q < bright}};
`else
  assign lit = pattern_q;
`endif

  assign led       = (ACTIVE_LOW != 0) ? ~lit : lit;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: an abstract model (positions, fill level, step phase)
// predicts each step, a monitor checks step_tick timing/patterns and the LED bus every clock.
module tb_led_pattern_seq;

  localparam int N        = 4;
  localparam int TICK_DIV = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         dir;
  logic [1:0]   speed;
  logic [N-1:0] led;
  logic         step_tick;
`ifdef LED_PWM_DIM_EN
  logic [3:0]   bright;
`endif

  led_pattern_seq #(
    .N_LED     (N),
    .CLK_HZ    (8),
    .STEP_HZ   (1),
    .ACTIVE_LOW(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .speed    (speed),
`ifdef LED_PWM_DIM_EN
    .bright   (bright),
`endif
    .led      (led),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_ref;
  always @(posedge clk or posedge rst) begin
    if (rst) pwm_ref <= '0;
    else     pwm_ref <= pwm_ref + 4'd1;
  end
`endif

  typedef struct {
    int           at;
    logic [N-1:0] pat;
  } exp_t;

  exp_t sb[$];

  // Reference model state: which mode, where the lit dot is, fill level, blink phase,
  // and how many enabled clocks have elapsed in the current step period.
  int m_mode, m_pos, m_step, m_level, m_phase;
  bit m_blink_on;

  function automatic logic [N-1:0] model_pattern();
    logic [N-1:0] p;
    p = '0;
    case (m_mode)
      0: p[m_pos] = 1'b1;
      1: p[(m_step < N) ? m_step : (2*N - 2 - m_step)] = 1'b1;
      2: p = m_blink_on ? '1 : '0;
      default: for (int i = 0; i < m_level; i++) p[i] = 1'b1;
    endcase
    return p;
  endfunction

  function automatic logic [N-1:0] exp_led(input logic [N-1:0] pat);
    logic [N-1:0] lit;
    lit = pat;
`ifdef LED_PWM_DIM_EN
    if (!(pwm_ref < bright)) lit = '0;
`endif
    return ~lit;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_step = 0; m_level = 0; m_phase = 0; m_blink_on = 1'b1;
  endtask

  // Applies the inputs currently driven to the upcoming rising edge.
  task automatic model_clock();
    if (int'(mode) != m_mode) begin
      m_mode  = int'(mode);
      m_phase = 0;
      case (m_mode)
        0: m_pos = dir ? N - 1 : 0;
        1: m_step = 0;
        2: m_blink_on = 1'b1;
        default: m_level = 0;
      endcase
    end else if (en) begin
      m_phase++;
      if (m_phase >= (TICK_DIV >> speed)) begin
        m_phase = 0;
        case (m_mode)
          0: m_pos = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
          1: m_step = (m_step + 1) % (2*N - 2);
          2: m_blink_on = !m_blink_on;
          default: m_level = (m_level + 1) % (N + 1);
        endcase
        sb.push_back('{at: cyc + 1, pat: model_pattern()});
      end
    end
  endtask

  task automatic chk_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; each iteration covers one rising edge.
  task automatic run(input int n);
    repeat (n) begin
      if (!rst) model_clock();
      @(negedge clk);
    end
  endtask

  // Monitor: pops expected steps when step_tick is seen, and tracks the LED bus every clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      if (step_tick) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_tick: step_tick high at cycle %0d, none expected", cyc);
        end else begin
          e = sb.pop_front();
          chk_int("tick_cycle", cyc, e.at);
          chk_vec("tick_led", led, exp_led(e.pat));
        end
      end else if (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL tick_missing: step_tick low at cycle %0d, expected high with pattern %b", e.at, e.pat);
      end
      chk_vec("led_track", led, exp_led(model_pattern()));
    end
  end

  initial begin
    int guard;
    rst   = 1'b1;
    en    = 1'b0;
    mode  = 2'd0;
    dir   = 1'b0;
    speed = 2'd0;
`ifdef LED_PWM_DIM_EN
    bright = 4'd4;
`endif
    model_reset();
    #1;
    chk_vec("reset_led", led, exp_led(4'b0001));
    chk_int("reset_tick", int'(step_tick), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Rotate left then right.
    en = 1'b1;
    run(40);
    dir = 1'b1;
    run(20);
    dir = 1'b0;

    // Bounce across both ends.
    mode = 2'd1;
    run(8 * 9 + 2);

    // Rotate, then switch to fill partway through a step period.
    mode = 2'd0;
    run(6);
    mode = 2'd3;
    run(1);
    chk_vec("mode_change_init", led, 4'b1111);
    run(8 * 5 + 4);

    // Raise speed mid-count, then freeze with en=0 and resume.
    speed = 2'd3;
    run(6);
    speed = 2'd1;
    run(9);
    speed = 2'd0;
    run(3);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(12);

    // Asynchronous reset between edges while the fill bar shows 0111.
    guard = 0;
    while (model_pattern() != 4'b0111 && guard < 200) begin
      run(1);
      guard++;
    end
    chk_vec("fill_reach_0111", model_pattern(), 4'b0111);
    #2;
    rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    chk_vec("async_reset_led", led, 4'b1110);
    chk_int("async_reset_tick", int'(step_tick), 0);
    repeat (3) begin
      @(negedge clk);
      chk_int("reset_hold_tick", int'(step_tick), 0);
    end
    rst = 1'b0;
    run(20);

    // Randomized segments.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      dir   = 1'($urandom_range(0, 1));
      speed = 2'($urandom_range(0, 3));
      en    = ($urandom_range(0, 4) != 0);
`ifdef LED_PWM_DIM_EN
      bright = 4'($urandom_range(0, 15));
`endif
      run($urandom_range(1, 20));
    end
    en = 1'b1;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
